// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one ripple-carry add/sub among NUM_REQ requesters.
// Grant in IDLE, result on rsp_* two cycles later; no new grant while a response waits on rsp_ready.
module addsub_rr_scheduler #(
  parameter int SIZE    = 4,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*SIZE-1:0] req_a,
  input  logic [NUM_REQ*SIZE-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [SIZE-1:0]         rsp_s,
  output logic                    rsp_cout,
  output logic                    rsp_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [SIZE-1:0]   op_a;
  logic [SIZE-1:0]   op_b;
  logic              op_sub;
  logic [ID_W-1:0]   op_id;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    sel;
  int                 idx;

  logic [SIZE-1:0]    b_x;
  logic [SIZE-1:0]    sum;
  logic [SIZE:0]      carry;

  // Scan starts just after the last winner, so the previous owner has lowest priority.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    sel      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (grant == '0 && req_valid[sel]) begin
        grant[sel] = 1'b1;
        grant_id   = sel;
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;

  // Shared ripple-carry chain: subtract is A + ~B + 1.
  always_comb begin
    b_x      = op_b ^ {SIZE{op_sub}};
    sum      = '0;
    carry    = '0;
    carry[0] = op_sub;
    for (int i = 0; i < SIZE; i++) begin
      sum[i]     = op_a[i] ^ b_x[i] ^ carry[i];
      carry[i+1] = (op_a[i] & b_x[i]) | (carry[i] & (op_a[i] ^ b_x[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != '0) begin
            op_a   <= req_a[grant_id*SIZE +: SIZE];
            op_b   <= req_b[grant_id*SIZE +: SIZE];
            op_sub <= req_sub[grant_id];
            op_id  <= grant_id;
            ptr    <= grant_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_s     <= sum;
          rsp_cout  <= carry[SIZE];
          rsp_ovf   <= carry[SIZE] ^ carry[SIZE-1];
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
